spi_flash_reader: RTL and testbench
===================================

Name: spi_flash_reader

Overview:
- SPI-mode-0 flash read initiator for the user project area.
- Issues a standard READ (0x03) command with a 24-bit address to an external SPI flash (same pinout as the spiflash sim model: csb/clk/io0/io1), then streams the returned bytes out on a valid/ready interface.
- Lets user logic, e.g. the rgb_mixer, load tables or presets from a flash on mprj_io pins without the management core.

Parameters:
- CLK_DIV, 2, flash_clk half-period in clock cycles (legal 1..255).
- CS_GAP, 4, minimum clock cycles flash_csb stays high after a transfer before busy drops (legal >=1).

Ports:
- clock  input  1  system clock
- resetb  input  1  asynchronous active-low reset
- start  input  1  one-cycle request; sampled only when busy=0
- addr  input  24  flash byte address, captured on start
- len  input  8  bytes to read, captured on start; 0 means 256
- busy  output  1  high from the cycle after start until the gap completes
- done  output  1  one-cycle pulse when busy falls
- data_out  output  8  received byte
- data_valid  output  1  data_out holds an unconsumed byte
- data_ready  input  1  consumer accepts data_out when data_valid && data_ready
- flash_csb  output  1  chip select, active low
- flash_clk  output  1  SPI clock, idle low (mode 0)
- flash_io0  output  1  MOSI
- flash_io1  input  1  MISO

Behaviour:
- Reset, asynchronous, any state:
  - flash_csb=1, flash_clk=0, flash_io0=0.
  - busy=0, done=0, data_valid=0, data_out=8'h00.
  - FSM goes to IDLE.
  - A reset mid-transfer aborts the transfer with no done pulse.
- States:
  - IDLE: start=1 captures addr and len, loads the 32-bit shift register {8'h03, addr}, moves to SEL, busy=1 next cycle. start is ignored in all other states.
  - SEL: flash_csb=0 with io0 = bit 31, held for CLK_DIV cycles, then CMD.
  - CMD: 32 bits out, MSB first.
    - io0 changes only while flash_clk is low, at the falling edge.
    - flash_clk high for CLK_DIV cycles, then low for CLK_DIV cycles.
    - After the 32nd falling edge, go to DATA.
  - DATA: 8 further clock pulses. flash_io1 is sampled into the receive shift register on the clock cycle flash_clk rises, MSB first. io0 is held 0.
  - Byte complete (8th falling edge):
    - If data_valid=0, or it is being consumed this cycle: load data_out, set data_valid=1.
    - Otherwise go to HOLD.
    - After the last byte, go to END. Otherwise start the next byte.
  - HOLD: flash_clk held low, csb held low, no edges. Wait until data_valid && data_ready, then transfer the pending byte into data_out the following cycle and continue as above.
  - END: flash_csb=1 immediately. Wait CS_GAP cycles and until data_valid=0, then busy=0, done=1 for one cycle, return to IDLE.
- data_valid clears on data_valid && data_ready unless a new byte loads the same cycle. A simultaneous load keeps valid=1 with the new data.
- Edge counts per transfer: exactly 32 + 8*N rising flash_clk edges, N = len or 256.
- flash_clk never glitches. Each high and each low phase is >= CLK_DIV cycles.
- Address is not range-checked. Wrap at 24'hFFFFFF is left to the flash.
- Counters:
  - bit counter 6 bits
  - byte counter 9 bits (len=0 maps to 256)
  - divider 8 bits

Test Plan:
- Single byte: spiflash model has 0xA5 at 0x000010; start with addr=0x000010, len=1, data_ready=1 -> io0 bitstream 0x03,0x00,0x00,0x10; exactly 40 rising edges; data_out=0xA5 with one valid pulse; done pulses once; busy drops CS_GAP cycles after csb rises.
- Burst: bytes 0x11,0x22,0x33,0x44 at 0x000100; len=4, data_ready=1 -> four accepted bytes in order; csb low continuously; 64 rising edges total.
- Backpressure: len=3 with data_ready=0 for 50 cycles after the first valid -> flash_clk frozen low in HOLD; csb stays low; all 3 bytes delivered intact and in order after ready returns; done only after the last byte is accepted.
- len=0 from 0x000000 -> 256 bytes delivered, matching the hex file; 2080 rising edges.
- Reset mid-transfer: assert resetb=0 during the address phase -> csb=1 and flash_clk=0 within the same cycle; no done; a new transfer afterwards reads correctly.
- start pulsed while busy -> ignored: no restart, captured addr unchanged. CLK_DIV=1 rerun of the single-byte case passes.

Source files
------------

// File: rtl/spi_flash_reader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_flash_reader_if : request/stream bundle for the SPI flash reader      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface spi_flash_reader_if;
   logic        start;
   logic [23:0] addr;
   logic [7:0]  len;
   logic        busy;
   logic        done;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;

   modport master (
      output start, addr, len, data_ready,
      input  busy, done, data_out, data_valid
   );

   modport slave (
      input  start, addr, len, data_ready,
      output busy, done, data_out, data_valid
   );
endinterface
`default_nettype wire

// File: rtl/spi_flash_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | spi_flash_reader : SPI mode-0 READ (0x03) initiator, bytes out on v/r     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module spi_flash_reader #(
   parameter int CLK_DIV = 2,
   parameter int CS_GAP  = 4
) (
   input  wire logic         clock,
   input  wire logic         resetb,
   spi_flash_reader_if.slave bus,
   output logic              flash_csb,
   output logic              flash_clk,
   output logic              flash_io0,
   input  wire logic         flash_io1
);
   localparam logic [2:0] c_idle = 3'd0;
   localparam logic [2:0] c_sel  = 3'd1;
   localparam logic [2:0] c_cmd  = 3'd2;
   localparam logic [2:0] c_data = 3'd3;
   localparam logic [2:0] c_hold = 3'd4;
   localparam logic [2:0] c_end  = 3'd5;

   localparam logic [7:0] c_read_cmd = 8'h03;
   localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
   localparam int         GAP_W      = $clog2(CS_GAP + 1);
   localparam logic [GAP_W-1:0] c_gap_last = GAP_W'(CS_GAP - 1);

   logic [2:0]       r_state;
   logic             r_csb;
   logic             r_sclk;
   logic [31:0]      r_shift;
   logic [7:0]       r_rx;
   logic [7:0]       r_pending;
   logic [7:0]       r_data_out;
   logic             r_valid;
   logic             r_busy;
   logic             r_done;
   logic [5:0]       r_bit_cnt;
   logic [8:0]       r_byte_cnt;
   logic [7:0]       r_div;
   logic [GAP_W-1:0] r_gap;

   logic w_div_end;
   logic w_consume;

   assign w_div_end = (r_div == c_div_last);
   assign w_consume = r_valid && bus.data_ready;

   // MOSI is the shift register MSB; zero fill leaves io0 low once the command is out
   assign flash_io0      = r_shift[31];
   assign flash_csb      = r_csb;
   assign flash_clk      = r_sclk;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.data_out   = r_data_out;
   assign bus.data_valid = r_valid;

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         r_state    <= c_idle;
         r_csb      <= 1'b1;
         r_sclk     <= 1'b0;
         r_shift    <= '0;
         r_rx       <= '0;
         r_pending  <= '0;
         r_data_out <= '0;
         r_valid    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_bit_cnt  <= '0;
         r_byte_cnt <= '0;
         r_div      <= '0;
         r_gap      <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_consume) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            c_idle: begin
               if (bus.start) begin
                  r_shift    <= {c_read_cmd, bus.addr};
                  r_byte_cnt <= (bus.len == 8'd0) ? 9'd256 : {1'b0, bus.len};
                  r_csb      <= 1'b0;
                  r_div      <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= c_sel;
               end
            end

            c_sel: begin
               if (w_div_end) begin
                  r_sclk    <= 1'b1;
                  r_div     <= '0;
                  r_bit_cnt <= '0;
                  r_state   <= c_cmd;
               end else begin
                  r_div <= r_div + 8'd1;
               end
            end

            c_cmd: begin
               if (!w_div_end) begin
                  r_div <= r_div + 8'd1;
               end else begin
                  r_div <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                  end else begin
                     r_sclk  <= 1'b0;
                     r_shift <= {r_shift[30:0], 1'b0};
                     if (r_bit_cnt == 6'd31) begin
                        r_bit_cnt <= '0;
                        r_state   <= c_data;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                     end
                  end
               end
            end

            c_data: begin
               if (!w_div_end) begin
                  r_div <= r_div + 8'd1;
               end else begin
                  r_div <= '0;
                  if (!r_sclk) begin
                     r_sclk <= 1'b1;
                     r_rx   <= {r_rx[6:0], flash_io1};
                  end else begin
                     r_sclk <= 1'b0;
                     if (r_bit_cnt == 6'd7) begin
                        r_bit_cnt  <= '0;
                        r_byte_cnt <= r_byte_cnt - 9'd1;
                        if (!r_valid || w_consume) begin
                           r_data_out <= r_rx;
                           r_valid    <= 1'b1;
                           if (r_byte_cnt == 9'd1) begin
                              r_csb   <= 1'b1;
                              r_gap   <= '0;
                              r_state <= c_end;
                           end
                        end else begin
                           r_pending <= r_rx;
                           r_state   <= c_hold;
                        end
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 6'd1;
                     end
                  end
               end
            end

            // Clock frozen low until the consumer frees data_out
            c_hold: begin
               if (w_consume) begin
                  r_data_out <= r_pending;
                  r_valid    <= 1'b1;
                  if (r_byte_cnt == 9'd0) begin
                     r_csb   <= 1'b1;
                     r_gap   <= '0;
                     r_state <= c_end;
                  end else begin
                     r_div   <= '0;
                     r_state <= c_data;
                  end
               end
            end

            c_end: begin
               if (r_gap != c_gap_last) begin
                  r_gap <= r_gap + 1'b1;
               end else if (!r_valid) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= c_idle;
               end
            end

            default: begin
               r_state <= c_idle;
            end
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_spi_flash_reader.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for spi_flash_reader: two instances (CLK_DIV 2 and 1) share stimulus,
// each talks to its own behavioural SPI flash model.
module tb_spi_flash_reader;
   localparam int GAP = 4;
   typedef logic [7:0] bq_t[$];

   logic        clock = 1'b0;
   logic        resetb;
   logic        start = 1'b0;
   logic [23:0] addr = '0;
   logic [7:0]  len = '0;
   logic        data_ready = 1'b1;
   logic [7:0]  mem [0:4095];
   int          n_eval = 0;
   int          n_fail = 0;
   int          q_base [2];
   int          done_base [2];
   int          fall_base [2];

   always #5 clock = ~clock;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int DIV = (k == 0) ? 2 : 1;
      spi_flash_reader_if bus ();
      logic       csb, sclk, io0;
      logic       io1 = 1'b0;
      logic       busy, done, valid;
      logic [7:0] dout;

      assign bus.start      = start;
      assign bus.addr       = addr;
      assign bus.len        = len;
      assign bus.data_ready = data_ready;
      assign busy           = bus.busy;
      assign done           = bus.done;
      assign valid          = bus.data_valid;
      assign dout           = bus.data_out;

      spi_flash_reader #(.CLK_DIV(DIV), .CS_GAP(GAP)) u_dut (
         .clock     (clock),
         .resetb    (resetb),
         .bus       (bus),
         .flash_csb (csb),
         .flash_clk (sclk),
         .flash_io0 (io0),
         .flash_io1 (io1)
      );

      // Flash model: 32 command/address bits in, then data bits out on falling edges
      int          bitn = 0, rises = 0, csb_falls = 0, io_bad_a = 0;
      logic [31:0] cmd = '0;
      always @(negedge csb or posedge sclk) begin
         if (sclk === 1'b1 && csb === 1'b0) begin
            if (bitn < 32) cmd = {cmd[30:0], io0};
            else if (io0 !== 1'b0) io_bad_a++;
            bitn++;
            rises++;
         end else if (csb === 1'b0) begin
            bitn = 0;
            rises = 0;
            cmd = '0;
            csb_falls++;
         end
      end
      always @(negedge sclk) begin
         int d;
         if (csb === 1'b0 && bitn >= 32) begin
            d = bitn - 32;
            io1 = mem[12'(cmd[23:0] + 24'(d / 8))][7 - (d % 8)];
         end
      end

      // Consumer and protocol monitor
      bq_t  rxq;
      int   done_cnt = 0, done_bad = 0, io_bad_b = 0, run = 0;
      int   min_hi = 1000, min_lo = 1000, cyc = 0, csb_rise_cyc = 0, busy_fall_cyc = 0;
      logic prev_sclk = 1'b0, prev_csb = 1'b1, prev_busy = 1'b0, prev_io0 = 1'b0, active = 1'b0;
      always @(negedge clock) begin
         cyc++;
         if (!resetb || csb) begin
            active = 1'b0;
            run    = 0;
         end else if (sclk == prev_sclk) begin
            run++;
         end else begin
            if (active) begin
               if (prev_sclk) min_hi = (run < min_hi) ? run : min_hi;
               else           min_lo = (run < min_lo) ? run : min_lo;
            end
            active = 1'b1;
            run    = 1;
         end
         if (resetb) begin
            if (valid && data_ready) rxq.push_back(dout);
            if (done) begin
               done_cnt++;
               if (valid || !prev_busy) done_bad++;
            end
            if (csb && !prev_csb) csb_rise_cyc = cyc;
            if (!busy && prev_busy) busy_fall_cyc = cyc;
            if (sclk && prev_sclk && io0 !== prev_io0) io_bad_b++;
         end
         prev_sclk = sclk;
         prev_csb  = csb;
         prev_busy = busy;
         prev_io0  = io0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      q_base[0] = g_dut[0].rxq.size();   q_base[1] = g_dut[1].rxq.size();
      done_base[0] = g_dut[0].done_cnt;  done_base[1] = g_dut[1].done_cnt;
      fall_base[0] = g_dut[0].csb_falls; fall_base[1] = g_dut[1].csb_falls;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, " csb0"}, 64'(g_dut[0].csb), 64'(1));   chk({tag, " csb1"}, 64'(g_dut[1].csb), 64'(1));
      chk({tag, " sclk0"}, 64'(g_dut[0].sclk), 64'(0)); chk({tag, " sclk1"}, 64'(g_dut[1].sclk), 64'(0));
      chk({tag, " io0_0"}, 64'(g_dut[0].io0), 64'(0));  chk({tag, " io0_1"}, 64'(g_dut[1].io0), 64'(0));
      chk({tag, " busy0"}, 64'(g_dut[0].busy), 64'(0)); chk({tag, " busy1"}, 64'(g_dut[1].busy), 64'(0));
      chk({tag, " done0"}, 64'(g_dut[0].done), 64'(0)); chk({tag, " done1"}, 64'(g_dut[1].done), 64'(0));
      chk({tag, " valid0"}, 64'(g_dut[0].valid), 64'(0)); chk({tag, " valid1"}, 64'(g_dut[1].valid), 64'(0));
      chk({tag, " dout0"}, 64'(g_dut[0].dout), 64'(0)); chk({tag, " dout1"}, 64'(g_dut[1].dout), 64'(0));
   endtask

   task automatic check_inst(input string tag, input int k, input logic [23:0] a, input int n,
                             input int rises, input logic [31:0] cmd, input bq_t q, input int dones,
                             input int falls, input int gap, input bit chk_gap);
      int bad = 0;
      string t = $sformatf("%s[%0d]", tag, k);
      chk({t, " cmd"}, 64'(cmd), 64'({8'h03, a}));
      chk({t, " rises"}, 64'(rises), 64'(32 + 8 * n));
      chk({t, " nbytes"}, 64'(q.size() - q_base[k]), 64'(n));
      for (int i = 0; i < n && q_base[k] + i < q.size(); i++)
         if (q[q_base[k] + i] !== mem[12'(a + 24'(i))]) bad++;
      chk({t, " byte_errors"}, 64'(bad), 64'(0));
      chk({t, " done_pulses"}, 64'(dones - done_base[k]), 64'(1));
      chk({t, " csb_falls"}, 64'(falls - fall_base[k]), 64'(1));
      if (chk_gap) chk({t, " cs_gap"}, 64'(gap), 64'(GAP));
   endtask

   task automatic check_both(input string tag, input logic [23:0] a, input int n, input bit chk_gap);
      check_inst(tag, 0, a, n, g_dut[0].rises, g_dut[0].cmd, g_dut[0].rxq, g_dut[0].done_cnt,
                 g_dut[0].csb_falls, g_dut[0].busy_fall_cyc - g_dut[0].csb_rise_cyc, chk_gap);
      check_inst(tag, 1, a, n, g_dut[1].rises, g_dut[1].cmd, g_dut[1].rxq, g_dut[1].done_cnt,
                 g_dut[1].csb_falls, g_dut[1].busy_fall_cyc - g_dut[1].csb_rise_cyc, chk_gap);
   endtask

   task automatic pulse_start(input logic [23:0] a, input logic [7:0] l);
      @(posedge clock); #1;
      addr = a; len = l; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; addr = 24'($urandom); len = 8'($urandom);
   endtask

   task automatic wait_idle(input string tag, input bit rand_ready, input int poke);
      int c = 0;
      while ((g_dut[0].busy || g_dut[1].busy) && c < 20000) begin
         if (rand_ready) data_ready = 1'($urandom_range(0, 1));
         if (c == poke) begin
            start = 1'b1; addr = 24'h00ABCD; len = 8'd7;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         c++;
      end
      start = 1'b0;
      data_ready = 1'b1;
      chk({tag, " finished_in_budget"}, 64'(c < 20000), 64'(1));
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic run_xfer(input string tag, input logic [23:0] a, input logic [7:0] l,
                           input bit rand_ready, input int poke);
      snap();
      pulse_start(a, l);
      wait_idle(tag, rand_ready, poke);
      check_both(tag, a, (l == 8'd0) ? 256 : int'(l), !rand_ready);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          r0, r1, c;
      logic [23:0] ra;
      logic [7:0]  rl;
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      mem[12'h010] = 8'hA5;
      mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;

      resetb = 1'b1;
      #2 resetb = 1'b0;
      #1 check_idle("reset");
      repeat (3) @(posedge clock);
      #1 resetb = 1'b1;

      run_xfer("single", 24'h000010, 8'd1, 1'b0, -1);
      run_xfer("burst", 24'h000100, 8'd4, 1'b0, -1);

      // Backpressure: ready low for 50 cycles after first valid
      snap();
      data_ready = 1'b0;
      pulse_start(24'h000100, 8'd3);
      c = 0;
      while (!g_dut[0].valid && c < 1000) begin @(posedge clock); #1; c++; end
      chk("bp first_valid_in_budget", 64'(c < 1000), 64'(1));
      repeat (40) @(posedge clock);
      #1;
      r0 = g_dut[0].rises;
      r1 = g_dut[1].rises;
      chk("bp hold_rises0", 64'(r0), 64'(48));
      chk("bp hold_rises1", 64'(r1), 64'(48));
      repeat (10) @(posedge clock);
      #1;
      chk("bp frozen0", 64'(g_dut[0].rises), 64'(r0));
      chk("bp frozen1", 64'(g_dut[1].rises), 64'(r1));
      chk("bp sclk_low0", 64'(g_dut[0].sclk), 64'(0));
      chk("bp csb_low0", 64'(g_dut[0].csb), 64'(0));
      chk("bp csb_low1", 64'(g_dut[1].csb), 64'(0));
      chk("bp held_byte0", 64'(g_dut[0].dout), 64'(8'h11));
      chk("bp no_done0", 64'(g_dut[0].done_cnt - done_base[0]), 64'(0));
      data_ready = 1'b1;
      wait_idle("bp", 1'b0, -1);
      check_both("bp", 24'h000100, 3, 1'b1);

      run_xfer("len0", 24'h000000, 8'd0, 1'b0, -1);

      // Reset during the address phase
      snap();
      pulse_start(24'h000123, 8'd4);
      c = 0;
      while (g_dut[0].rises < 16 && c < 1000) begin @(posedge clock); #1; c++; end
      chk("abort in_addr_phase", 64'(g_dut[0].rises >= 9 && g_dut[0].rises < 32), 64'(1));
      resetb = 1'b0;
      #1 check_idle("abort");
      repeat (2) @(posedge clock);
      #1 resetb = 1'b1;
      repeat (20) @(posedge clock);
      #1;
      chk("abort no_done0", 64'(g_dut[0].done_cnt - done_base[0]), 64'(0));
      chk("abort no_done1", 64'(g_dut[1].done_cnt - done_base[1]), 64'(0));
      run_xfer("after_abort", 24'h000200, 8'd3, 1'b0, -1);

      run_xfer("start_while_busy", 24'h000340, 8'd2, 1'b0, 20);

      for (int t = 0; t < 4; t++) begin
         ra = 24'($urandom);
         rl = 8'($urandom_range(1, 8));
         run_xfer($sformatf("rand%0d", t), ra, rl, 1'b1, -1);
      end

      chk("min_high0", 64'(g_dut[0].min_hi), 64'(2));
      chk("min_low0", 64'(g_dut[0].min_lo), 64'(2));
      chk("min_high1", 64'(g_dut[1].min_hi), 64'(1));
      chk("min_low1", 64'(g_dut[1].min_lo), 64'(1));
      chk("io0_rules0", 64'(g_dut[0].io_bad_a + g_dut[0].io_bad_b), 64'(0));
      chk("io0_rules1", 64'(g_dut[1].io_bad_a + g_dut[1].io_bad_b), 64'(0));
      chk("done_rules0", 64'(g_dut[0].done_bad), 64'(0));
      chk("done_rules1", 64'(g_dut[1].done_bad), 64'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
